// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the five-stage MIPS datapath.
// Produces stall/flush/forward selects from the stage specifiers, tracks the
// multicycle HI/LO multiplier with a two-state FSM, and counts stall cycles
// in a saturating counter.
module hazard_unit #(
  parameter int          CNT_W  = 16,
  parameter logic [2:0]  WB_MEM = 3'b001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       branchD,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic             MultD,
  input  logic             HiLoReadD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic             RegWriteE,
  input  logic [2:0]       WBSrcE,
  input  logic             MultStartE,
  input  logic             MultDoneE,
  input  logic [4:0]       WriteRegM,
  input  logic             RegWriteM,
  input  logic [2:0]       WBSrcM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteW,
  output logic             stallF,
  output logic             stallD,
  output logic             flushE,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             multBusy,
  output logic             multErr,
  output logic [CNT_W-1:0] stallCnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mult_state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  mult_state_t state_r;
  mult_state_t state_next_s;
  logic        err_set_s;
  logic        lwstall_s;
  logic        branchstall_s;
  logic        multstall_s;
  logic        stall_s;
  logic        fwd_ad_s;
  logic        fwd_bd_s;
  logic [1:0]  fwd_ae_s;
  logic [1:0]  fwd_be_s;

  // Register $0 is hardwired to zero, so a zero specifier never matches.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  // Execute-stage forward select: M result beats W result beats register file.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       wr_m,
                                         input logic [4:0] dst_m,
                                         input logic       wr_w,
                                         input logic [4:0] dst_w);
    logic [1:0] sel;
    if (wr_m && reg_match(src, dst_m)) begin
      sel = 2'b10;
    end else if (wr_w && reg_match(src, dst_w)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Hazard detection and forwarding selects from current-cycle specifiers.
  always_comb begin
    lwstall_s     = 1'b0;
    branchstall_s = 1'b0;
    multstall_s   = 1'b0;
    fwd_ad_s      = 1'b0;
    fwd_bd_s      = 1'b0;
    fwd_ae_s      = 2'b00;
    fwd_be_s      = 2'b00;

    // A load in E cannot feed Decode until it reaches W.
    lwstall_s = (WBSrcE == WB_MEM) &&
                (reg_match(WriteRegE, RsD) || reg_match(WriteRegE, RtD));

    // Branch comparators live in Decode: wait out an E writer, and a load in M.
    if (branchD != 2'b00) begin
      branchstall_s = (RegWriteE &&
                       (reg_match(WriteRegE, RsD) || reg_match(WriteRegE, RtD))) ||
                      ((WBSrcM == WB_MEM) &&
                       (reg_match(WriteRegM, RsD) || reg_match(WriteRegM, RtD)));
    end else begin
      branchstall_s = 1'b0;
    end

    // HI/LO users wait until the in-flight multiply has written its result.
    multstall_s = ((state_r == BUSY) || MultStartE) && (MultD || HiLoReadD);

    // Decode comparator may only take M-stage ALU results, never load data.
    fwd_ad_s = RegWriteM && reg_match(RsD, WriteRegM) && (WBSrcM != WB_MEM);
    fwd_bd_s = RegWriteM && reg_match(RtD, WriteRegM) && (WBSrcM != WB_MEM);

    fwd_ae_s = fwd_sel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
    fwd_be_s = fwd_sel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
  end

  // While reset is held every hazard/forward output is forced inactive.
  always_comb begin
    stall_s   = 1'b0;
    forwardAD = 1'b0;
    forwardBD = 1'b0;
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (rst) begin
      stall_s   = 1'b0;
    end else begin
      stall_s   = lwstall_s | branchstall_s | multstall_s;
      forwardAD = fwd_ad_s;
      forwardBD = fwd_bd_s;
      forwardAE = fwd_ae_s;
      forwardBE = fwd_be_s;
    end
  end

  assign stallF = stall_s;
  assign stallD = stall_s;
  assign flushE = stall_s;

  // Multiplier FSM next state; a start while busy without a done is an error.
  always_comb begin
    state_next_s = state_r;
    err_set_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (MultStartE && !MultDoneE) begin
          state_next_s = BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        if (MultDoneE && !MultStartE) begin
          state_next_s = IDLE;
        end else if (MultStartE && !MultDoneE) begin
          state_next_s = BUSY;
          err_set_s    = 1'b1;
        end else begin
          state_next_s = BUSY;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Multiplier FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  assign multBusy = (state_r == BUSY);

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      multErr <= 1'b0;
    end else if (err_set_s) begin
      multErr <= 1'b1;
    end else begin
      multErr <= multErr;
    end
  end

  // Saturating count of cycles with Decode stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt <= {CNT_W{1'b0}};
    end else if (stall_s && (stallCnt != CNT_MAX)) begin
      stallCnt <= stallCnt + CNT_ONE;
    end else begin
      stallCnt <= stallCnt;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model of the hazard rules.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] branchD;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       MultD, HiLoReadD, RegWriteE, MultStartE, MultDoneE;
  logic       RegWriteM, RegWriteW;
  logic [2:0] WBSrcE, WBSrcM;
  logic       stallF, stallD, flushE, forwardAD, forwardBD;
  logic [1:0] forwardAE, forwardBE;
  logic       multBusy, multErr;
  logic [3:0] stallCnt;

  int checks   = 0;
  int failures = 0;

  // model state
  logic m_busy = 1'b0;
  logic m_err  = 1'b0;
  int   m_cnt  = 0;

  hazard_unit #(.CNT_W(4), .WB_MEM(3'b001)) dut (
    .clk(clk), .rst(rst), .branchD(branchD), .RsD(RsD), .RtD(RtD),
    .MultD(MultD), .HiLoReadD(HiLoReadD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .RegWriteE(RegWriteE), .WBSrcE(WBSrcE),
    .MultStartE(MultStartE), .MultDoneE(MultDoneE), .WriteRegM(WriteRegM),
    .RegWriteM(RegWriteM), .WBSrcM(WBSrcM), .WriteRegW(WriteRegW),
    .RegWriteW(RegWriteW), .stallF(stallF), .stallD(stallD), .flushE(flushE),
    .forwardAD(forwardAD), .forwardBD(forwardBD), .forwardAE(forwardAE),
    .forwardBE(forwardBE), .multBusy(multBusy), .multErr(multErr),
    .stallCnt(stallCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Does Decode read register r?
  function automatic logic d_reads(input logic [4:0] r);
    return (r != 5'd0) && ((r == RsD) || (r == RtD));
  endfunction

  function automatic logic exp_stall();
    logic lw, br, ml;
    if (rst) return 1'b0;
    lw = (WBSrcE == 3'b001) && d_reads(WriteRegE);
    br = (branchD != 2'b00) &&
         ((RegWriteE && d_reads(WriteRegE)) || ((WBSrcM == 3'b001) && d_reads(WriteRegM)));
    ml = (m_busy || MultStartE) && (MultD || HiLoReadD);
    return lw || br || ml;
  endfunction

  function automatic logic [1:0] exp_fwd_e(input logic [4:0] r);
    if (rst || r == 5'd0) return 2'b00;
    if (RegWriteM && WriteRegM == r) return 2'b10;
    if (RegWriteW && WriteRegW == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic exp_fwd_d(input logic [4:0] r);
    return !rst && (r != 5'd0) && RegWriteM && (WriteRegM == r) && (WBSrcM != 3'b001);
  endfunction

  // Reference model state: multiplier occupancy, error flag, stall count.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_err  <= 1'b0;
      m_cnt  <= 0;
    end else begin
      if (exp_stall()) m_cnt <= (m_cnt < 15) ? m_cnt + 1 : 15;
      if (m_busy) begin
        if (MultStartE && !MultDoneE) m_err <= 1'b1;
        if (MultDoneE && !MultStartE) m_busy <= 1'b0;
      end else if (MultStartE && !MultDoneE) begin
        m_busy <= 1'b1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("m_stallF",    {31'd0, stallF},    {31'd0, exp_stall()});
    chk("m_stallD",    {31'd0, stallD},    {31'd0, exp_stall()});
    chk("m_flushE",    {31'd0, flushE},    {31'd0, exp_stall()});
    chk("m_forwardAD", {31'd0, forwardAD}, {31'd0, exp_fwd_d(RsD)});
    chk("m_forwardBD", {31'd0, forwardBD}, {31'd0, exp_fwd_d(RtD)});
    chk("m_forwardAE", {30'd0, forwardAE}, {30'd0, exp_fwd_e(RsE)});
    chk("m_forwardBE", {30'd0, forwardBE}, {30'd0, exp_fwd_e(RtE)});
    chk("m_multBusy",  {31'd0, multBusy},  {31'd0, m_busy});
    chk("m_multErr",   {31'd0, multErr},   {31'd0, m_err});
    chk("m_stallCnt",  {28'd0, stallCnt},  m_cnt[31:0]);
  end

  task automatic clear_inputs();
    branchD = 2'd0; RsD = 5'd0; RtD = 5'd0; MultD = 1'b0; HiLoReadD = 1'b0;
    RsE = 5'd0; RtE = 5'd0; WriteRegE = 5'd0; RegWriteE = 1'b0; WBSrcE = 3'd0;
    MultStartE = 1'b0; MultDoneE = 1'b0; WriteRegM = 5'd0; RegWriteM = 1'b0;
    WBSrcM = 3'd0; WriteRegW = 5'd0; RegWriteW = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic nchk();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int nb;
    int ns;
    clear_inputs();
    // reset holds outputs inactive even with a live hazard present
    WBSrcE = 3'd1; WriteRegE = 5'd8; RtD = 5'd8; RegWriteM = 1'b1; WriteRegM = 5'd3; RsE = 5'd3;
    nchk();
    chk("rst_stallD", {31'd0, stallD}, 32'd0);
    chk("rst_fwdAE", {30'd0, forwardAE}, 32'd0);
    chk("rst_cnt", {28'd0, stallCnt}, 32'd0);
    cyc(); rst = 1'b0; clear_inputs();

    // forwarding priority
    RsE = 5'd5; RegWriteM = 1'b1; WriteRegM = 5'd5; RegWriteW = 1'b1; WriteRegW = 5'd5;
    nchk(); chk("fwd_m_prio", {30'd0, forwardAE}, 32'd2);
    RegWriteM = 1'b0; #1; chk("fwd_w", {30'd0, forwardAE}, 32'd1);
    RsE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd0; RegWriteM = 1'b1; #1;
    chk("fwd_r0", {30'd0, forwardAE}, 32'd0);
    cyc(); clear_inputs();

    // load-use: one bubble
    WBSrcE = 3'd1; WriteRegE = 5'd8; RegWriteE = 1'b1; RtD = 5'd8;
    nchk(); chk("lu_stallF", {31'd0, stallF}, 32'd1); chk("lu_flushE", {31'd0, flushE}, 32'd1);
    chk("lu_cnt0", {28'd0, stallCnt}, 32'd0);
    cyc(); clear_inputs();
    WBSrcM = 3'd1; WriteRegM = 5'd8; RegWriteM = 1'b1; RtE = 5'd8;
    nchk(); chk("lu_nostall", {31'd0, stallD}, 32'd0); chk("lu_fwdBE_m", {30'd0, forwardBE}, 32'd2);
    chk("lu_cnt1", {28'd0, stallCnt}, 32'd1);
    cyc(); clear_inputs();
    RegWriteW = 1'b1; WriteRegW = 5'd8; RtE = 5'd8;
    nchk(); chk("lu_fwdBE_w", {30'd0, forwardBE}, 32'd1);
    cyc(); clear_inputs();

    // branch after load: two bubbles
    branchD = 2'd1; RsD = 5'd9; WBSrcE = 3'd1; WriteRegE = 5'd9; RegWriteE = 1'b1;
    nchk(); chk("bl_stall1", {31'd0, stallD}, 32'd1);
    cyc(); clear_inputs();
    branchD = 2'd1; RsD = 5'd9; WBSrcM = 3'd1; WriteRegM = 5'd9; RegWriteM = 1'b1;
    nchk(); chk("bl_stall2", {31'd0, stallD}, 32'd1); chk("bl_fwdAD_load", {31'd0, forwardAD}, 32'd0);
    cyc(); clear_inputs();
    branchD = 2'd1; RsD = 5'd9; RegWriteW = 1'b1; WriteRegW = 5'd9;
    nchk(); chk("bl_release", {31'd0, stallD}, 32'd0); chk("bl_cnt", {28'd0, stallCnt}, 32'd3);
    cyc(); clear_inputs();

    // branch after ALU op: one bubble, then D-stage forward
    branchD = 2'd2; RtD = 5'd7; RegWriteE = 1'b1; WriteRegE = 5'd7;
    nchk(); chk("ab_stall", {31'd0, stallD}, 32'd1);
    cyc(); clear_inputs();
    branchD = 2'd2; RtD = 5'd7; RegWriteM = 1'b1; WriteRegM = 5'd7;
    nchk(); chk("ab_nostall", {31'd0, stallD}, 32'd0); chk("ab_fwdBD", {31'd0, forwardBD}, 32'd1);
    cyc(); clear_inputs();

    // multicycle multiply with HI/LO reader waiting
    nb = 0; ns = 0;
    for (int i = 0; i < 8; i++) begin
      HiLoReadD = 1'b1;
      MultStartE = (i == 0);
      MultDoneE  = (i == 4);
      nchk();
      nb += int'(multBusy);
      ns += int'(stallD);
      cyc();
    end
    chk("mult_busy_cycles", nb, 32'd4);
    chk("mult_stall_cycles", ns, 32'd5);
    clear_inputs();

    // single-cycle op never enters BUSY
    MultStartE = 1'b1; MultDoneE = 1'b1;
    nchk(); cyc(); clear_inputs();
    nchk(); chk("single_busy", {31'd0, multBusy}, 32'd0);
    cyc();

    // protocol violation: second start while busy
    MultStartE = 1'b1;
    nchk(); cyc(); clear_inputs();
    MultStartE = 1'b1;
    nchk(); chk("pe_busy", {31'd0, multBusy}, 32'd1);
    cyc(); clear_inputs();
    nchk(); chk("pe_err", {31'd0, multErr}, 32'd1);
    cyc();
    nchk(); chk("pe_sticky", {31'd0, multErr}, 32'd1); chk("pe_still_busy", {31'd0, multBusy}, 32'd1);

    // asynchronous reset mid-multiply
    RsE = 5'd5; RegWriteM = 1'b1; WriteRegM = 5'd5; HiLoReadD = 1'b1; RsD = 5'd5;
    #1 rst = 1'b1;
    #1;
    chk("ar_busy", {31'd0, multBusy}, 32'd0);
    chk("ar_err", {31'd0, multErr}, 32'd0);
    chk("ar_cnt", {28'd0, stallCnt}, 32'd0);
    chk("ar_fwdAE", {30'd0, forwardAE}, 32'd0);
    chk("ar_fwdAD", {31'd0, forwardAD}, 32'd0);
    chk("ar_stall", {31'd0, stallF}, 32'd0);
    cyc(); cyc(); rst = 1'b0; clear_inputs();

    // saturation at 15
    WBSrcE = 3'd1; WriteRegE = 5'd4; RsD = 5'd4;
    repeat (20) cyc();
    nchk(); chk("sat_cnt", {28'd0, stallCnt}, 32'd15);
    cyc(); clear_inputs();

    // randomized traffic, checked by the every-cycle model comparison
    for (int i = 0; i < 600; i++) begin
      branchD    = 2'($urandom_range(0, 3));
      RsD        = 5'($urandom_range(0, 3));
      RtD        = 5'($urandom_range(0, 3));
      RsE        = 5'($urandom_range(0, 3));
      RtE        = 5'($urandom_range(0, 3));
      WriteRegE  = 5'($urandom_range(0, 3));
      WriteRegM  = 5'($urandom_range(0, 3));
      WriteRegW  = 5'($urandom_range(0, 3));
      RegWriteE  = 1'($urandom_range(0, 1));
      RegWriteM  = 1'($urandom_range(0, 1));
      RegWriteW  = 1'($urandom_range(0, 1));
      WBSrcE     = 3'($urandom_range(0, 4));
      WBSrcM     = 3'($urandom_range(0, 4));
      MultD      = ($urandom_range(0, 5) == 0);
      HiLoReadD  = ($urandom_range(0, 5) == 0);
      MultStartE = ($urandom_range(0, 7) == 0);
      MultDoneE  = ($urandom_range(0, 3) == 0);
      rst        = ((i % 150) == 149);
      cyc();
    end
    rst = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage MIPS `datapath`. Drives the stall, flush and forwarding selects that `datapath` consumes, using the register specifiers, write-back sources and multiplier handshake it exports. It is the only block that sequences the pipeline around data hazards. It tracks the multicycle HI/LO multiplier with a two-state FSM and keeps a saturating stall-cycle counter.

## Interface
- `CNT_W`, 16: width of the stall-cycle counter.
- `WB_MEM`, 3'b001: `WBSrc` code for load (memory) results. Other codes: 000 ALU, 010 HI, 011 LO, 100 link.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `branchD`  in  2  nonzero = branch/jump-register in Decode, compared in D.
- `RsD`, `RtD`  in  5 each  Decode source specifiers.
- `MultD`, `HiLoReadD`  in  1 each  Decode holds mult/div, or mfhi/mflo.
- `RsE`, `RtE`, `WriteRegE`  in  5 each  Execute specifiers.
- `RegWriteE`  in  1  Execute writes the register file.
- `WBSrcE`  in  3  Execute write-back source.
- `MultStartE`, `MultDoneE`  in  1 each  multiplier start pulse, and result written to HI/LO this cycle.
- `WriteRegM`  in  5  Memory-stage destination register.
- `RegWriteM`  in  1  Memory-stage register write enable.
- `WBSrcM`  in  3  Memory-stage write-back source.
- `WriteRegW`  in  5  Writeback-stage destination register.
- `RegWriteW`  in  1  Writeback-stage register write enable.
- `stallF`, `stallD`, `flushE`  out  1 each  hold PC, hold IF/ID, bubble ID/EX.
- `forwardAD`, `forwardBD`  out  1 each  Decode comparator operands taken from the M-stage ALU result.
- `forwardAE`, `forwardBE`  out  2 each  00 register file, 01 W result, 10 M result.
- `multBusy`  out  1  FSM in BUSY.
- `multErr`  out  1  sticky protocol-error flag.
- `stallCnt`  out  `CNT_W`  cycles with `stallD` high, saturating.

## Operation
- Register 0 never matches: any specifier equal to 0 disables the forward or stall term that uses it.
- E forwarding for `RsE` (same for `RtE`/`forwardBE`):
  - 10 if `RegWriteM` and `WriteRegM == RsE`;
  - else 01 if `RegWriteW` and `WriteRegW == RsE`;
  - else 00. M has priority over W.
- `forwardAD` = `RegWriteM` && `WriteRegM == RsD` && `WBSrcM != WB_MEM`. `forwardBD` is the same with `RtD`.
- `lwstall` = `WBSrcE == WB_MEM` && `WriteRegE` ∈ {`RsD`, `RtD`}.
- `branchstall` = `branchD != 0` && any of:
  - `RegWriteE` && `WriteRegE` ∈ {`RsD`, `RtD`};
  - `WBSrcM == WB_MEM` && `WriteRegM` ∈ {`RsD`, `RtD`}.
- `multstall` = (`multBusy` || `MultStartE`) && (`MultD` || `HiLoReadD`).
- `stallF` = `stallD` = `flushE` = `lwstall` | `branchstall` | `multstall`.
- Multiplier FSM, two states:
  - IDLE: `MultStartE` && !`MultDoneE` → BUSY. `MultStartE` && `MultDoneE` (single-cycle op) → stay IDLE.
  - BUSY: `MultDoneE` && !`MultStartE` → IDLE. `MultDoneE` && `MultStartE` (back-to-back) → stay BUSY.
  - BUSY: `MultStartE` without `MultDoneE` is a protocol violation. Set `multErr`, stay BUSY.
  - `multErr` clears only on reset.
- `stallCnt` increments on every edge where `stallD` is 1. It holds at all-ones.

## Timing
- All hazard and forward outputs are combinational from current-cycle inputs plus FSM state; zero-cycle latency.
- `multBusy`, `multErr` and `stallCnt` are registered and change one edge after their cause.
- Multiplier stall release: `multstall` stays high in the cycle `MultDoneE` is high, because HI/LO is written at the end of that cycle. It drops the next cycle.
- Load-use costs exactly one bubble. Branch after ALU op costs one bubble. Branch after load costs two.
- Reset, asynchronous and effective immediately, including mid-multiply:
  - FSM → IDLE; `multBusy`, `multErr` = 0; `stallCnt` = 0;
  - while `rst` is high, `stallF`, `stallD`, `flushE`, `forwardAD`, `forwardBD` are forced to 0 and `forwardAE`, `forwardBE` to 00.
- First counted edge is the first rising edge after `rst` falls.

## Test plan
- Forward priority: `RsE`=5, M writes $5, W writes $5 → `forwardAE`=10. Drop `RegWriteM` → 01. Set `RsE`=0 with both writing $0 → 00.
- Load-use: `WBSrcE`=001, `WriteRegE`=8, `RtD`=8 → stalls and flush high one cycle. Next cycle (load in M, `RtE`=8) → `forwardBE`=01 after W advance, no stall. `stallCnt` 0→1.
- Branch after load: `branchD`=01, `RsD`=9, load to $9 in E → stall. Load in M → stall. Then `forwardAD`=0 and no stall → exactly two bubbles.
- Multiplier:
  - `MultStartE` pulse, `MultDoneE` 4 cycles later, `HiLoReadD`=1 throughout → `multBusy` 1 for 4 cycles and stall for 5 cycles (start cycle through done cycle).
  - Start+done in same IDLE cycle → `multBusy` stays 0.
- Protocol/reset: second `MultStartE` while BUSY → `multErr`=1 sticky. Assert `rst` mid-BUSY → `multBusy`, `multErr`, `stallCnt` = 0 immediately, all stall/forward outputs 0 while `rst` high.
- Saturation with `CNT_W`=4: hold a stall 20 cycles → `stallCnt` stops at 15.
